// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the data-cache AXI memory responder: response codes,
// responder state encoding and the beat width.
package ysyx_22050019_axi_pkg;

    localparam int BEAT_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W,
        ST_B_WAIT,
        ST_B,
        ST_R_WAIT,
        ST_R
    } resp_state_e;

endpackage

// File: rtl/ysyx_22050019_mem_array.sv
// Backing word array: combinational read port, clocked byte-enable write port.
// Contents are deliberately not reset.
module ysyx_22050019_mem_array
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [BEAT_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [BEAT_W-1:0]   wr_data,
    input  logic [BEAT_W/8-1:0] wr_strb
);

    logic [BEAT_W-1:0] mem [MEM_WORDS];

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BEAT_W / 8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_mem_resp.sv
// Memory-side AXI responder for the data cache refill/write-back port (1- or 2-beat bursts).
// Optional MEM_RESP_DELAY_EN inserts RESP_DELAY wait cycles before the first R beat and before B.
module ysyx_22050019_axi_mem_resp
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                    MEM_WORDS  = 4096,
    parameter int                    RESP_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic                  rw_len_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [7:0]            w_strb_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [1:0]            b_resp_o,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [1:0]            r_resp_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_last_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    resp_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  len_q, cnt_q, err_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic                  load_rd, dly_done;
    logic                  aw_hs, ar_hs, w_hs, r_hs;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic                  rd_cnt, rd_oor, wr_oor, wr_en;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic cnt);
        return ((addr - BASE_ADDR) >> 3) + ADDR_WIDTH'(cnt);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr, input logic cnt);
        return (addr < BASE_ADDR) || (word_of(addr, cnt) >= ADDR_WIDTH'(MEM_WORDS));
    endfunction

`ifdef MEM_RESP_DELAY_EN
    localparam int DLY_W   = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam bit WAIT_EN = (RESP_DELAY > 0);

    logic [DLY_W-1:0] dly_q;

    // Loaded on entry to a wait state; the FSM leaves the wait state when it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else if ((state_d == ST_B_WAIT || state_d == ST_R_WAIT) && state_d != state_q) begin
            dly_q <= DLY_W'(RESP_DELAY - 1);
        end else if (dly_q != '0) begin
            dly_q <= dly_q - DLY_W'(1);
        end
    end

    assign dly_done = (dly_q == '0);
`else
    localparam bit WAIT_EN = 1'b0;

    assign dly_done = 1'b1;
`endif

    // The write address wins a same-cycle AW/AR collision.
    assign aw_ready_o = (state_q == ST_IDLE);
    assign ar_ready_o = (state_q == ST_IDLE) && !aw_valid_i;
    assign w_ready_o  = (state_q == ST_W);
    assign b_valid_o  = (state_q == ST_B);
    assign r_valid_o  = (state_q == ST_R);
    assign r_last_o   = (state_q == ST_R) && (cnt_q == len_q);
    assign b_resp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;
    assign w_hs  = w_valid_i && w_ready_o;
    assign r_hs  = r_valid_o && r_ready_i;

    // Read data is fetched for beat 0 out of IDLE/R_WAIT, and for beat 1 while beat 0 is accepted.
    assign rd_base = (state_q == ST_IDLE) ? ar_addr_i : base_q;
    assign rd_cnt  = (state_q == ST_R);
    assign rd_oor  = out_of_range(rd_base, rd_cnt);
    assign rd_idx  = IDX_W'(word_of(rd_base, rd_cnt));

    assign wr_oor  = out_of_range(base_q, cnt_q);
    assign wr_idx  = IDX_W'(word_of(base_q, cnt_q));
    assign wr_en   = w_hs && !wr_oor && !rst;

    ysyx_22050019_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (w_data_i),
        .wr_strb (w_strb_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aw_valid_i) begin
                    state_d = ST_W;
                end else if (ar_valid_i) begin
                    state_d = WAIT_EN ? ST_R_WAIT : ST_R;
                    load_rd = !WAIT_EN;
                end
            end
            ST_W: begin
                if (w_valid_i && cnt_q == len_q) begin
                    state_d = WAIT_EN ? ST_B_WAIT : ST_B;
                end
            end
            ST_B_WAIT: begin
                if (dly_done) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (b_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_R_WAIT: begin
                if (dly_done) begin
                    state_d = ST_R;
                    load_rd = 1'b1;
                end
            end
            ST_R: begin
                if (r_ready_i) begin
                    if (r_last_o) begin
                        state_d = ST_IDLE;
                    end else begin
                        load_rd = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            base_q <= aw_addr_i;
            len_q  <= rw_len_i;
        end else if (ar_hs) begin
            base_q <= ar_addr_i;
            len_q  <= rw_len_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 1'b0;
            err_q    <= 1'b0;
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else begin
            if (aw_hs || ar_hs) begin
                cnt_q <= 1'b0;
            end else if (w_hs || (r_hs && !r_last_o)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (aw_hs) begin
                err_q <= 1'b0;
            end else if (w_hs && wr_oor) begin
                err_q <= 1'b1;
            end
            if (load_rd) begin
                r_data_q <= rd_oor ? '0 : rd_data;
                r_resp_q <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_mem_resp.sv
// Directed + randomized bench for ysyx_22050019_axi_mem_resp against a word-level memory model.
module tb_ysyx_22050019_axi_mem_resp;

    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          DLY   = 4;
`ifdef MEM_RESP_DELAY_EN
    localparam int LAT = 1 + DLY;
`else
    localparam int LAT = 1;
`endif

    logic        clk, rst;
    logic        aw_valid_i, aw_ready_o, rw_len_i;
    logic [31:0] aw_addr_i, ar_addr_i;
    logic        w_valid_i, w_ready_o;
    logic [63:0] w_data_i, r_data_o;
    logic [7:0]  w_strb_i;
    logic        b_valid_o, b_ready_i;
    logic [1:0]  b_resp_o, r_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic        r_valid_o, r_ready_i, r_last_o;

    int cmp = 0;
    int err = 0;
    logic [63:0] model [int];

    ysyx_22050019_axi_mem_resp #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (WORDS),
        .RESP_DELAY (DLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_addr_i  (aw_addr_i),
        .rw_len_i   (rw_len_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_resp_o   (b_resp_o),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_addr_i  (ar_addr_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_resp_o   (r_resp_o),
        .r_data_o   (r_data_o),
        .r_last_o   (r_last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp)
        else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit oor(input logic [31:0] addr, input int beat);
        longint a = longint'(addr);
        if (a < longint'(BASE)) return 1'b1;
        return ((a - longint'(BASE)) / 8 + beat) >= WORDS;
    endfunction

    function automatic int widx(input logic [31:0] addr, input int beat);
        return int'((longint'(addr) - longint'(BASE)) / 8) + beat;
    endfunction

    function automatic logic [63:0] exp_data(input logic [31:0] addr, input int beat);
        if (oor(addr, beat)) return 64'h0;
        if (model.exists(widx(addr, beat))) return model[widx(addr, beat)];
        return 64'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int beat,
                               input logic [63:0] d, input logic [7:0] s);
        logic [63:0] cur;
        if (!oor(addr, beat)) begin
            cur = model.exists(widx(addr, beat)) ? model[widx(addr, beat)] : 64'h0;
            for (int i = 0; i < 8; i++) if (s[i]) cur[i*8 +: 8] = d[i*8 +: 8];
            model[widx(addr, beat)] = cur;
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input bit len,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [7:0] s0, input logic [7:0] s1, input int bstall);
        logic [63:0] d [2];
        logic [7:0]  s [2];
        logic [1:0]  er;
        int          n;
        d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
        er = 2'b00;
        @(negedge clk);
        aw_valid_i = 1'b1; aw_addr_i = addr; rw_len_i = len;
        #1 chk("aw_ready_idle", aw_ready_o, 1);
        @(negedge clk);
        aw_valid_i = 1'b0; aw_addr_i = $urandom; rw_len_i = 1'($urandom);
        chk("w_ready_after_aw", w_ready_o, 1);
        for (int b = 0; b <= int'(len); b++) begin
            w_valid_i = 1'b1; w_data_i = d[b]; w_strb_i = s[b];
            chk("w_ready_beat", w_ready_o, 1);
            if (oor(addr, b)) er = 2'b10;
            model_write(addr, b, d[b], s[b]);
            @(negedge clk);
        end
        w_valid_i = 1'b0;
        chk("w_ready_drop", w_ready_o, 0);
        n = 1;
        while (!b_valid_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b_latency", n, LAT);
        chk("b_resp", b_resp_o, er);
        for (int i = 0; i < bstall; i++) begin
            @(negedge clk);
            chk("b_hold_valid", b_valid_o, 1);
            chk("b_hold_resp", b_resp_o, er);
        end
        b_ready_i = 1'b1;
        @(negedge clk);
        b_ready_i = 1'b0;
        chk("aw_ready_after_b", aw_ready_o, 1);
        chk("b_valid_after_b", b_valid_o, 0);
    endtask

    // Entered at the negedge whose following posedge performs the AR handshake.
    task automatic read_collect(input logic [31:0] addr, input bit len, input int stall);
        logic [63:0] ed;
        int          n;
        @(negedge clk);
        ar_valid_i = 1'b0; ar_addr_i = $urandom; rw_len_i = 1'($urandom);
        r_ready_i = (stall == 0);
        chk("ar_ready_busy", ar_ready_o, 0);
        n = 1;
        while (!r_valid_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("r_latency", n, LAT);
        for (int b = 0; b <= int'(len); b++) begin
            ed = exp_data(addr, b);
            if (b == 0) begin
                for (int i = 0; i < stall; i++) begin
                    chk("r_stall_valid", r_valid_o, 1);
                    chk("r_stall_data", r_data_o, ed);
                    @(negedge clk);
                end
                r_ready_i = 1'b1;
            end
            chk("r_valid", r_valid_o, 1);
            chk("r_data", r_data_o, ed);
            chk("r_resp", r_resp_o, oor(addr, b) ? 2'b10 : 2'b00);
            chk("r_last", r_last_o, (b == int'(len)));
            @(negedge clk);
        end
        r_ready_i = 1'b0;
        chk("r_valid_after_last", r_valid_o, 0);
        chk("ar_ready_after_r", ar_ready_o, 1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input bit len, input int stall);
        @(negedge clk);
        ar_valid_i = 1'b1; ar_addr_i = addr; rw_len_i = len;
        #1 chk("ar_ready_idle", ar_ready_o, 1);
        read_collect(addr, len, stall);
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] d0, d1;
        int          n;

        rst = 1'b1;
        aw_valid_i = 0; aw_addr_i = 0; rw_len_i = 0;
        w_valid_i = 0; w_data_i = 0; w_strb_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_addr_i = 0; r_ready_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", aw_ready_o, 1);
        chk("rst_ar_ready", ar_ready_o, 1);
        chk("rst_w_ready", w_ready_o, 0);
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_last", r_last_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_b_resp", b_resp_o, 0);
        chk("rst_r_resp", r_resp_o, 0);
        rst = 1'b0;

        // Known contents for the working window and the top word.
        for (int k = 0; k < 16; k++) write_burst(BASE + 32'(8 * k), 1'b0, 64'h0, 64'h0, 8'hFF, 8'h00, 0);
        write_burst(BASE + 32'(8 * WORDS) - 32'd8, 1'b0, 64'h7777_0000_7777_0000, 64'h0, 8'hFF, 8'h00, 0);

        // Two-beat read with no backpressure.
        write_burst(BASE + 32'h10, 1'b1, 64'h1111, 64'h2222, 8'hFF, 8'hFF, 0);
        read_burst(BASE + 32'h10, 1'b1, 0);

        // Strobed two-beat write, then readback of the partially written word.
        write_burst(BASE + 32'h20, 1'b1, {16{4'hA}}, {16{4'h5}}, 8'hFF, 8'h0F, 1);
        read_burst(BASE + 32'h28, 1'b0, 0);

        // Backpressure on beat 0.
        read_burst(BASE + 32'h20, 1'b1, 3);

        // Same-cycle AW and AR: write goes first, AR waits for B.
        @(negedge clk);
        aw_valid_i = 1; aw_addr_i = BASE + 32'h30; rw_len_i = 0;
        ar_valid_i = 1; ar_addr_i = BASE + 32'h30;
        #1 chk("coll_aw_ready", aw_ready_o, 1);
        chk("coll_ar_ready", ar_ready_o, 0);
        @(negedge clk);
        aw_valid_i = 0;
        chk("coll_ar_blocked_w", ar_ready_o, 0);
        w_valid_i = 1; w_data_i = 64'hC0FF_EE00_1234_5678; w_strb_i = 8'hFF;
        model_write(BASE + 32'h30, 0, w_data_i, w_strb_i);
        @(negedge clk);
        w_valid_i = 0;
        n = 1;
        while (!b_valid_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("coll_b_latency", n, LAT);
        chk("coll_ar_blocked_b", ar_ready_o, 0);
        b_ready_i = 1;
        @(negedge clk);
        b_ready_i = 0; rw_len_i = 1;
        #1 chk("coll_ar_ready_after_b", ar_ready_o, 1);
        read_collect(BASE + 32'h30, 1'b1, 0);

        // Top of memory: second beat runs off the end.
        read_burst(BASE + 32'(8 * WORDS) - 32'd8, 1'b1, 0);
        write_burst(BASE + 32'(8 * WORDS) - 32'd8, 1'b1, 64'h1234, 64'h5678, 8'hFF, 8'hFF, 0);
        read_burst(BASE + 32'(8 * WORDS) - 32'd8, 1'b0, 0);

        // Below the base address.
        write_burst(BASE - 32'd8, 1'b0, 64'hDEAD, 64'h0, 8'hFF, 8'h00, 0);
        read_burst(BASE - 32'd8, 1'b1, 0);

        // Reset after the first beat of a two-beat write.
        a = BASE + 32'h40;
        @(negedge clk);
        aw_valid_i = 1; aw_addr_i = a; rw_len_i = 1;
        @(negedge clk);
        aw_valid_i = 0;
        w_valid_i = 1; w_data_i = 64'hFEED_FACE_0BAD_F00D; w_strb_i = 8'hFF;
        model_write(a, 0, w_data_i, w_strb_i);
        @(negedge clk);
        w_valid_i = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_aw_ready", aw_ready_o, 1);
        chk("mid_rst_w_ready", w_ready_o, 0);
        chk("mid_rst_b_valid", b_valid_o, 0);
        read_burst(a, 1'b1, 0);

        // Randomized traffic over the window; address bits [2:0] are noise.
        for (int it = 0; it < 40; it++) begin
            a  = BASE + 32'(8 * $urandom_range(0, 14)) + 32'($urandom_range(0, 7));
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                write_burst(a, 1'($urandom), d0, d1, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
            else
                read_burst(a, 1'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
